// File: rtl/event_capture_pkg.sv
// Shared sizing, FSM state type and priority encoder for the event capture block.
package event_capture_pkg;

    localparam int N           = 8;
    localparam int IDX_W       = $clog2(N);
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // Index of the highest set bit; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] highest_set(input logic [N-1:0] bits);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bits[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/event_capture_if.sv
// Code/valid/ready handshake between the event capture block and the encoder stage.
interface event_capture_if;

    logic [event_capture_pkg::IDX_W-1:0] code_out;
    logic                                valid;
    logic                                ready;

    modport master (output code_out, output valid, input ready);
    modport slave  (input code_out, input valid, output ready);

endinterface

// File: rtl/sync_rise_detect.sv
// Synchronizes one asynchronous request line and emits a one-cycle rise pulse.
module sync_rise_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], req_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/event_capture_8.sv
// Latches synchronized request rises as pending bits and presents the highest
// pending index over a valid/ready handshake, clearing it on acceptance.
module event_capture_8
    import event_capture_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N-1:0]         req_in,
    output logic [N-1:0]         pending,
    output logic                 overflow,
    event_capture_if.master      cap
);

    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    state_e           state_q, state_d;

    for (genvar i = 0; i < N; i++) begin : g_line
        sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .req_in (req_in[i]),
            .rise   (rise[i])
        );
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (enable && (pending_q != '0)) begin
                    code_d  = highest_set(pending_q);
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (cap.ready) begin
                    clr     = {{(N-1){1'b0}}, 1'b1} << code_q;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
        // A rise landing on the bit being accepted re-arms it and is not an overflow.
        pending_d  = (pending_q & ~clr) | rise;
        overflow_d = |(rise & pending_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            valid_q    <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign cap.code_out = code_q;
    assign cap.valid    = valid_q;
    assign pending      = pending_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_event_capture_8.sv
// Directed bench for event_capture_8 with hand-computed expectations.
module tb_event_capture_8;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] req_in;
    logic [7:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    event_capture_if cap_if ();

    event_capture_8 dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .req_in   (req_in),
        .pending  (pending),
        .overflow (overflow),
        .cap      (cap_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        req_in       = 8'h00;
        cap_if.ready = 1'b0;
        tick(2);
        check("rst_valid", 32'(cap_if.valid), 32'd0);
        check("rst_code", 32'(cap_if.code_out), 32'd0);
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: single event, ready held high
        enable = 1'b1; cap_if.ready = 1'b1; req_in = 8'h04;
        tick(2);
        check("t1_pend_e1", 32'(pending), 32'h00);
        req_in = 8'h00;
        tick(1);
        check("t1_pend_e2", 32'(pending), 32'h04);
        check("t1_valid_e2", 32'(cap_if.valid), 32'd0);
        tick(1);
        check("t1_valid_e3", 32'(cap_if.valid), 32'd1);
        check("t1_code_e3", 32'(cap_if.code_out), 32'd2);
        tick(1);
        check("t1_valid_e4", 32'(cap_if.valid), 32'd0);
        check("t1_pend_e4", 32'(pending), 32'h00);
        tick(2);

        // 2: two simultaneous events, priority and hold
        cap_if.ready = 1'b0; req_in = 8'h81;
        tick(2);
        req_in = 8'h00;
        tick(1);
        check("t2_pend", 32'(pending), 32'h81);
        tick(1);
        check("t2_code7", 32'(cap_if.code_out), 32'd7);
        check("t2_valid7", 32'(cap_if.valid), 32'd1);
        tick(2);
        check("t2_hold_code", 32'(cap_if.code_out), 32'd7);
        check("t2_hold_valid", 32'(cap_if.valid), 32'd1);
        cap_if.ready = 1'b1;
        tick(1);
        check("t2_bubble_valid", 32'(cap_if.valid), 32'd0);
        check("t2_bubble_pend", 32'(pending), 32'h01);
        tick(1);
        check("t2_code0", 32'(cap_if.code_out), 32'd0);
        check("t2_valid0", 32'(cap_if.valid), 32'd1);
        tick(1);
        check("t2_done_valid", 32'(cap_if.valid), 32'd0);
        check("t2_done_pend", 32'(pending), 32'h00);
        tick(2);

        // 3: overflow on a pending, unaccepted line
        cap_if.ready = 1'b0; req_in = 8'h20;
        tick(2);
        req_in = 8'h00;
        tick(2);
        check("t3_code5", 32'(cap_if.code_out), 32'd5);
        check("t3_valid5", 32'(cap_if.valid), 32'd1);
        req_in = 8'h20;
        tick(1);
        check("t3_no_ovf_early", 32'(overflow), 32'd0);
        tick(1);
        req_in = 8'h00;
        tick(1);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_pend", 32'(pending), 32'h20);
        tick(1);
        check("t3_ovf_pulse", 32'(overflow), 32'd0);
        check("t3_code_held", 32'(cap_if.code_out), 32'd5);
        cap_if.ready = 1'b1;
        tick(1);
        check("t3_acc_valid", 32'(cap_if.valid), 32'd0);
        check("t3_acc_pend", 32'(pending), 32'h00);
        tick(3);
        check("t3_no_redeliver", 32'(cap_if.valid), 32'd0);
        tick(1);

        // 4: enable gating
        enable = 1'b0; req_in = 8'h10;
        tick(2);
        req_in = 8'h00;
        tick(1);
        check("t4_pend", 32'(pending), 32'h10);
        check("t4_valid_off", 32'(cap_if.valid), 32'd0);
        tick(2);
        check("t4_valid_still_off", 32'(cap_if.valid), 32'd0);
        enable = 1'b1;
        tick(1);
        check("t4_valid_on", 32'(cap_if.valid), 32'd1);
        check("t4_code4", 32'(cap_if.code_out), 32'd4);
        tick(1);
        check("t4_acc_pend", 32'(pending), 32'h00);
        tick(2);

        // 5: reset mid-handshake
        cap_if.ready = 1'b0; req_in = 8'h08;
        tick(2);
        req_in = 8'h00;
        tick(2);
        check("t5_code3", 32'(cap_if.code_out), 32'd3);
        check("t5_valid3", 32'(cap_if.valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(cap_if.valid), 32'd0);
        check("t5_rst_pend", 32'(pending), 32'h00);
        check("t5_rst_code", 32'(cap_if.code_out), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(5);
        check("t5_idle_pend", 32'(pending), 32'h00);
        check("t5_idle_valid", 32'(cap_if.valid), 32'd0);
        check("t5_idle_ovf", 32'(overflow), 32'd0);

        // 6: rise coinciding with acceptance of the same line
        cap_if.ready = 1'b0; req_in = 8'h40;
        tick(2);
        req_in = 8'h00;
        tick(2);
        check("t6_code6", 32'(cap_if.code_out), 32'd6);
        req_in = 8'h40;
        tick(2);
        req_in = 8'h00; cap_if.ready = 1'b1;
        tick(1);
        check("t6_acc_valid", 32'(cap_if.valid), 32'd0);
        check("t6_pend_kept", 32'(pending), 32'h40);
        check("t6_no_ovf", 32'(overflow), 32'd0);
        tick(1);
        check("t6_re_valid", 32'(cap_if.valid), 32'd1);
        check("t6_re_code", 32'(cap_if.code_out), 32'd6);
        check("t6_re_no_ovf", 32'(overflow), 32'd0);
        tick(1);
        check("t6_done_pend", 32'(pending), 32'h00);
        check("t6_done_valid", 32'(cap_if.valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/event_capture_8.md
# event_capture_8

Captures asynchronous rising-edge events on eight request lines and latches each one as a pending bit. It presents the highest-index pending event as a 3-bit binary code over a valid/ready handshake. It sits directly upstream of the 8-to-3 encoding stage and replaces its raw one-hot input with synchronized, arbitrated and flow-controlled codes. Each pending bit is cleared only when the downstream stage accepts its code.

## Interface
- N, 8, number of request lines; fixed at 8 for this release.
- IDX_W, 3, code width; equals clog2(N).
- SYNC_STAGES, 2, synchronizer depth per request line; legal range 2 to 3.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  grant enable; when low, no new code is presented.
- req_in  input  N  asynchronous request lines; events are rising edges only.
- code_out  output  IDX_W  index of the event being presented.
- valid  output  1  code_out holds a presented event.
- ready  input  1  downstream accepts code_out when valid and ready are both high at a rising edge.
- pending  output  N  registered pending bitmap.
- overflow  output  1  one-cycle pulse when an edge arrives on a line whose pending bit is already set.

## Operation
- Each line passes through SYNC_STAGES flops, then one previous-value flop. The rise condition is sync_last & ~prev.
- A rise sets pending[i].
- A rise on a line with pending[i] already set leaves the bit set and pulses overflow in the next cycle. One pulse is produced regardless of how many lines overflow.
- The FSM has two states, IDLE and PRESENT.
- IDLE: if enable = 1 and pending ≠ 0, register code_out = highest set index, assert valid, and go to PRESENT. Otherwise stay in IDLE with valid = 0.
- PRESENT: code_out and valid stay stable until the handshake. Changes in pending, enable or req_in do not alter them.
- On valid & ready: clear pending[code_out], deassert valid, and return to IDLE.
- Simultaneous set and clear of the same bit: set wins. The bit stays pending and is re-presented later. No overflow pulse is produced in this case.
- enable low while in PRESENT: the current code stays presented until it is accepted.
- Arbitration is fixed priority, highest index first; there is no fairness guarantee.
- Reset values: every synchronizer flop and prev flop 0, pending 0, code_out 0, valid 0, overflow 0, state IDLE.
- A line held high through reset release is seen as one rising edge once it propagates through the synchronizer.
- Reset asserted mid-handshake clears everything immediately. A code that was presented but not accepted is lost.

## Timing
- Input edge to pending: req_in rises before edge 0. pending[i] is visible after edge SYNC_STAGES (edge 2 at the default).
- Pending to valid: the next edge (edge 3 at default), provided the FSM is in IDLE and enable = 1.
- Throughput: at most one code per 2 cycles. The handshake edge returns the FSM to IDLE, and the next grant is registered on the following edge, giving one bubble cycle.
- ready may be held high constantly; the minimum valid pulse is one cycle.
- overflow is registered and asserts one cycle after the offending rise condition.
- There are no combinational paths from any input to any output.

## Structure
- Shared package event_capture_pkg holds:
  - N, IDX_W and SYNC_STAGES defaults.
  - the state enum: IDLE, PRESENT.
  - a priority-encode function for the highest set bit.
- One sub-module, sync_rise_detect, instantiated per line. It contains the SYNC_STAGES flops and the prev flop, and outputs a one-cycle rise pulse.
- The top level contains the pending register, the FSM, the output registers and the overflow logic.

## Test plan
1. Reset, then pulse req_in = 8'b0000_0100 with ready = 1 and enable = 1 -> pending = 8'b0000_0100 after edge 2, valid with code_out = 2 at edge 3, valid and pending return to 0 one cycle later.
2. Raise req_in = 8'b1000_0001 together with ready = 0 -> code_out = 7 is presented and held. Assert ready -> 7 is accepted, a bubble cycle follows, then code_out = 0 is presented.
3. With bit 5 pending and unaccepted, produce a second rise on req_in[5] -> one overflow pulse, pending[5] stays 1, and only one code 5 is ever delivered.
4. enable = 0 with pending = 8'b0001_0000 -> valid stays 0. Raise enable -> code_out = 4 on the next edge.
5. Hold valid with code 3, then pulse rst for one cycle -> valid, pending and code_out are 0 immediately. After release, an idle req_in = 0 produces no events.
6. Bit 6 is being accepted (valid, ready, code 6) on the same cycle a new rise on line 6 sets it -> pending[6] remains 1 with no overflow pulse, and code 6 is presented again after the bubble.
